// File: rtl/uart_arb_pkg.sv
// Shared types and UART slot register map for the TX arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_HOLD
    } arb_state_e;

    localparam logic [4:0] REG_STATUS = 5'd0;
    localparam logic [4:0] REG_DVSR   = 5'd1;
    localparam logic [4:0] REG_WRITE  = 5'd2;
    localparam logic [4:0] REG_RXPOP  = 5'd3;

    localparam int TX_FULL_BIT  = 9;
    localparam int RX_EMPTY_BIT = 8;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    winner
);

    int   idx;
    logic found;

    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART slot's TX path among N_REQ byte streams.
// Optional stalled-lock timeout is compiled in with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [10:0] DVSR_INIT    = 11'd650,
    parameter int          LOCK_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0][7:0]     data,
    input  logic [N_REQ-1:0]          last,
    output logic [N_REQ-1:0]          ack,
    output logic                      cs,
    output logic                      read,
    output logic                      write,
    output logic [4:0]                addr,
    output logic [31:0]               wr_data,
    input  logic [31:0]               rd_data,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  owner
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e     state, state_nx;
    logic [IW-1:0]  owner_nx;
    logic [IW-1:0]  ptr, ptr_nx;
    logic [IW-1:0]  owner_inc;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic           tx_full;
    logic           hold_expired;

    assign tx_full   = rd_data[TX_FULL_BIT];
    assign owner_inc = IW'(wrap_inc(int'(owner), N_REQ));

    // Only the TX-full flag matters here; RX status belongs to another block.
    logic [30:0] unused_rd;
    assign unused_rd = {rd_data[31:TX_FULL_BIT+1], rd_data[TX_FULL_BIT-1:0]};

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_idx)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    logic [TW-1:0] hold_cnt;

    // Counts cycles spent in HOLD; zero on the first HOLD cycle.
    always_ff @(posedge clk) begin
        if (reset || state != ST_HOLD) hold_cnt <= '0;
        else                           hold_cnt <= hold_cnt + 1'b1;
    end

    assign hold_expired = (hold_cnt == TW'(LOCK_TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(LOCK_TIMEOUT);
    assign hold_expired   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        case (state)
            ST_INIT: state_nx = ST_IDLE;
            ST_IDLE: begin
                if (pick_any) begin
                    owner_nx = pick_idx;
                    state_nx = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!tx_full) state_nx = req[owner] ? ST_WRITE : ST_HOLD;
            end
            ST_WRITE: begin
                if (last[owner]) begin
                    state_nx = ST_IDLE;
                    ptr_nx   = owner_inc;
                end else begin
                    state_nx = ST_CHECK;
                end
            end
            ST_HOLD: begin
                // A returning owner wins over a timeout landing on the same cycle.
                if (req[owner]) begin
                    state_nx = ST_CHECK;
                end else if (hold_expired) begin
                    state_nx = ST_IDLE;
                    ptr_nx   = owner_inc;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = REG_STATUS;
        wr_data = '0;
        ack     = '0;
        if (!reset) begin
            case (state)
                ST_INIT: begin
                    cs      = 1'b1;
                    write   = 1'b1;
                    addr    = REG_DVSR;
                    wr_data = {21'h0, DVSR_INIT};
                end
                ST_CHECK: begin
                    cs   = 1'b1;
                    read = 1'b1;
                    addr = REG_STATUS;
                end
                ST_WRITE: begin
                    cs         = 1'b1;
                    write      = 1'b1;
                    addr       = REG_WRITE;
                    wr_data    = {24'h0, data[owner]};
                    ack[owner] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_CHECK) || (state == ST_WRITE) || (state == ST_HOLD);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-exact vector table, then randomized traffic vs a message-level model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N-1:0][7:0] data = '0;
    logic [N-1:0]      last = '0;
    logic [N-1:0]      ack;
    logic              cs, read, write, busy;
    logic [4:0]        addr;
    logic [31:0]       wr_data;
    logic [31:0]       rd_data = '0;
    logic [1:0]        owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DVSR_INIT(11'd650), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .last(last), .ack(ack),
        .cs(cs), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy), .owner(owner)
    );

    typedef struct {
        bit          rst;
        logic [3:0]  rq;
        logic [31:0] d;
        logic [3:0]  lst;
        bit          full;
        byte         ph;
        logic [7:0]  b;
        int          own;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input logic [3:0] rq, input logic [31:0] d,
                       input logic [3:0] lst, input bit full, input byte ph,
                       input logic [7:0] b, input int own);
        vec_t v;
        v.rst = rst; v.rq = rq; v.d = d; v.lst = lst; v.full = full;
        v.ph = ph; v.b = b; v.own = own;
        tbl.push_back(v);
    endtask

    // Expected bus view for a phase: N=divisor write, I=idle/quiet, C=status poll,
    // W=byte write, H=hold, R=strobes forced off by reset mid-message.
    function automatic logic [46:0] expect_out(input byte ph, input logic [7:0] b, input int own);
        logic c, r, w, bz;
        logic [4:0] a;
        logic [31:0] wd;
        logic [3:0] ak;
        c = 0; r = 0; w = 0; bz = 0; a = 0; wd = 0; ak = 0;
        case (ph)
            "N": begin c = 1; w = 1; a = 5'd1; wd = 32'd650; end
            "C": begin c = 1; r = 1; bz = 1; end
            "W": begin c = 1; w = 1; a = 5'd2; wd = {24'h0, b}; ak = 4'(1 << own); bz = 1; end
            "H", "R": bz = 1;
            default: ;
        endcase
        return {c, r, w, a, wd, ak, bz, 2'(own)};
    endfunction

    task automatic check(input string name, input logic [46:0] act, input logic [46:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [8:0]  rq_q[N][$];
    logic [8:0]  mq[N][$];
    logic [9:0]  exp_q[$];

    initial begin
        // ---------------- table ----------------
        add(1, 4'b0000, 32'h0, 4'b0000, 0, "I", 8'h00, 0);
        // single requester, 3-byte message
        add(0, 4'b0001, 32'h41, 4'b0000, 0, "N", 8'h00, 0);
        add(0, 4'b0001, 32'h41, 4'b0000, 0, "I", 8'h00, 0);
        add(0, 4'b0001, 32'h41, 4'b0000, 0, "C", 8'h00, 0);
        add(0, 4'b0001, 32'h41, 4'b0000, 0, "W", 8'h41, 0);
        add(0, 4'b0001, 32'h42, 4'b0000, 0, "C", 8'h00, 0);
        add(0, 4'b0001, 32'h42, 4'b0000, 0, "W", 8'h42, 0);
        add(0, 4'b0001, 32'h43, 4'b0001, 0, "C", 8'h00, 0);
        add(0, 4'b0001, 32'h43, 4'b0001, 0, "W", 8'h43, 0);
        add(0, 4'b0000, 32'h0,  4'b0000, 0, "I", 8'h00, 0);
        // tx_full held 5 cycles
        add(0, 4'b0001, 32'h55, 4'b0001, 0, "I", 8'h00, 0);
        for (int k = 0; k < 5; k++) add(0, 4'b0001, 32'h55, 4'b0001, 1, "C", 8'h00, 0);
        add(0, 4'b0001, 32'h55, 4'b0001, 0, "C", 8'h00, 0);
        add(0, 4'b0001, 32'h55, 4'b0001, 0, "W", 8'h55, 0);
        add(0, 4'b0000, 32'h0,  4'b0000, 0, "I", 8'h00, 0);
        // requesters 1 and 2, two bytes each
        add(0, 4'b0110, 32'h00B1A100, 4'b0000, 0, "I", 8'h00, 0);
        add(0, 4'b0110, 32'h00B1A100, 4'b0000, 0, "C", 8'h00, 1);
        add(0, 4'b0110, 32'h00B1A100, 4'b0000, 0, "W", 8'hA1, 1);
        add(0, 4'b0110, 32'h00B1A200, 4'b0010, 0, "C", 8'h00, 1);
        add(0, 4'b0110, 32'h00B1A200, 4'b0010, 0, "W", 8'hA2, 1);
        add(0, 4'b0100, 32'h00B10000, 4'b0000, 0, "I", 8'h00, 1);
        add(0, 4'b0100, 32'h00B10000, 4'b0000, 0, "C", 8'h00, 2);
        add(0, 4'b0100, 32'h00B10000, 4'b0000, 0, "W", 8'hB1, 2);
        add(0, 4'b0100, 32'h00B20000, 4'b0100, 0, "C", 8'h00, 2);
        add(0, 4'b0100, 32'h00B20000, 4'b0100, 0, "W", 8'hB2, 2);
        add(0, 4'b0000, 32'h0,        4'b0000, 0, "I", 8'h00, 2);
        // ptr is now 3: 0 and 3 both request, 3 goes first
        add(0, 4'b1001, 32'hC10000D1, 4'b1001, 0, "I", 8'h00, 2);
        add(0, 4'b1001, 32'hC10000D1, 4'b1001, 0, "C", 8'h00, 3);
        add(0, 4'b1001, 32'hC10000D1, 4'b1001, 0, "W", 8'hC1, 3);
        add(0, 4'b0001, 32'h000000D1, 4'b0001, 0, "I", 8'h00, 3);
        add(0, 4'b0001, 32'h000000D1, 4'b0001, 0, "C", 8'h00, 0);
        add(0, 4'b0001, 32'h000000D1, 4'b0001, 0, "W", 8'hD1, 0);
        add(0, 4'b0000, 32'h0,        4'b0000, 0, "I", 8'h00, 0);
        // owner 1 stalls 10 cycles mid-message while 2 waits
        add(0, 4'b0010, 32'h0000E100, 4'b0000, 0, "I", 8'h00, 0);
        add(0, 4'b0010, 32'h0000E100, 4'b0000, 0, "C", 8'h00, 1);
        add(0, 4'b0010, 32'h0000E100, 4'b0000, 0, "W", 8'hE1, 1);
        add(0, 4'b0100, 32'h00F10000, 4'b0100, 0, "C", 8'h00, 1);
        for (int k = 0; k < 10; k++) add(0, 4'b0100, 32'h00F10000, 4'b0100, 0, "H", 8'h00, 1);
        add(0, 4'b0110, 32'h00F1E200, 4'b0110, 0, "H", 8'h00, 1);
        add(0, 4'b0110, 32'h00F1E200, 4'b0110, 0, "C", 8'h00, 1);
        add(0, 4'b0110, 32'h00F1E200, 4'b0110, 0, "W", 8'hE2, 1);
        add(0, 4'b0100, 32'h00F10000, 4'b0100, 0, "I", 8'h00, 1);
        add(0, 4'b0100, 32'h00F10000, 4'b0100, 0, "C", 8'h00, 2);
        add(0, 4'b0100, 32'h00F10000, 4'b0100, 0, "W", 8'hF1, 2);
        add(0, 4'b0000, 32'h0,        4'b0000, 0, "I", 8'h00, 2);
        // reset in the middle of a message
        add(0, 4'b0100, 32'h00AA0000, 4'b0100, 0, "I", 8'h00, 2);
        add(0, 4'b0100, 32'h00AA0000, 4'b0100, 0, "C", 8'h00, 2);
        add(1, 4'b0100, 32'h00AA0000, 4'b0100, 0, "R", 8'h00, 2);
        add(1, 4'b0100, 32'h00AA0000, 4'b0100, 0, "I", 8'h00, 0);
        add(0, 4'b0100, 32'h00AA0000, 4'b0100, 0, "N", 8'h00, 0);
        add(0, 4'b0100, 32'h00AA0000, 4'b0100, 0, "I", 8'h00, 0);
        add(0, 4'b0100, 32'h00AA0000, 4'b0100, 0, "C", 8'h00, 2);
        add(0, 4'b0100, 32'h00AA0000, 4'b0100, 0, "W", 8'hAA, 2);
        add(0, 4'b0000, 32'h0,        4'b0000, 0, "I", 8'h00, 2);
`ifdef UART_ARB_TIMEOUT_EN
        // owner 3 stalls past the 16-cycle limit; requester 0 then gets the grant
        add(0, 4'b1000, 32'hC5000000, 4'b0000, 0, "I", 8'h00, 2);
        add(0, 4'b1000, 32'hC5000000, 4'b0000, 0, "C", 8'h00, 3);
        add(0, 4'b1000, 32'hC5000000, 4'b0000, 0, "W", 8'hC5, 3);
        add(0, 4'b0001, 32'h000000D5, 4'b0001, 0, "C", 8'h00, 3);
        for (int k = 0; k < 16; k++) add(0, 4'b0001, 32'h000000D5, 4'b0001, 0, "H", 8'h00, 3);
        add(0, 4'b0001, 32'h000000D5, 4'b0001, 0, "I", 8'h00, 3);
        add(0, 4'b0001, 32'h000000D5, 4'b0001, 0, "C", 8'h00, 0);
        add(0, 4'b0001, 32'h000000D5, 4'b0001, 0, "W", 8'hD5, 0);
        add(0, 4'b0000, 32'h0,        4'b0000, 0, "I", 8'h00, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            reset   = tbl[i].rst;
            req     = tbl[i].rq;
            data    = tbl[i].d;
            last    = tbl[i].lst;
            rd_data = tbl[i].full ? 32'h200 : 32'h0;
            #1;
            check($sformatf("vec%0d_%s", i, string'(tbl[i].ph)),
                  {cs, read, write, addr, wr_data, ack, busy, owner},
                  expect_out(tbl[i].ph, tbl[i].b, tbl[i].own));
            @(posedge clk);
            #1;
        end

        // ---------------- randomized traffic ----------------
        begin
            int p, cyc, pause[N];
            logic [N-1:0] ack_s;
            logic [8:0] e;
            logic [9:0] x;
            bit stalled;

            for (int i = 0; i < N; i++) begin
                int nm;
                nm = $urandom_range(1, 3);
                pause[i] = 0;
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        rq_q[i].push_back({b == len - 1, 8'($urandom)});
                end
                mq[i] = rq_q[i];
            end
            // message-level round robin: whole messages, pointer after last winner
            p = 0;
            while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0) begin
                int w;
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && mq[(p + k) % N].size() > 0) w = (p + k) % N;
                do begin
                    e = mq[w].pop_front();
                    exp_q.push_back({2'(w), e[7:0]});
                end while (!e[8]);
                p = (w + 1) % N;
            end

            reset = 1; req = '0; last = '0; rd_data = '0;
            @(posedge clk);
            #1;
            reset = 0;
            ack_s = '0;
            stalled = 0;
            cyc = 0;
            while (cyc < 20000 && exp_q.size() > 0) begin
                for (int i = 0; i < N; i++) begin
                    if (ack_s[i]) begin
                        e = rq_q[i].pop_front();
                        if (!e[8] && $urandom_range(0, 2) == 0) pause[i] = $urandom_range(1, 4);
                    end else if (pause[i] > 0) begin
                        pause[i]--;
                    end
                    req[i]  = (rq_q[i].size() > 0) && (pause[i] == 0);
                    data[i] = (rq_q[i].size() > 0) ? rq_q[i][0][7:0] : 8'h00;
                    last[i] = (rq_q[i].size() > 0) ? rq_q[i][0][8] : 1'b0;
                end
                rd_data = ($urandom_range(0, 3) == 0) ? 32'h200 : 32'h0;
                @(negedge clk);
                ack_s = ack;
                if (stalled) check("full_gate", 47'(write), 47'd0);
                if (write && addr == 5'd2) begin
                    if (exp_q.size() == 0) begin
                        check("extra_write", 47'(wr_data[7:0]), 47'h1FF);
                    end else begin
                        x = exp_q.pop_front();
                        check("rand_write", {ack, wr_data[7:0]}, {4'(1 << x[9:8]), x[7:0]});
                    end
                end else begin
                    check("ack_no_write", 47'(ack), 47'd0);
                end
                stalled = read && addr == 5'd0 && rd_data[9];
                @(posedge clk);
                #1;
                cyc++;
            end
            check("rand_drained", 47'(exp_q.size()), 47'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
